expr_char_tx: RTL

- Transmit side of the ASCII arithmetic-expression character stream.
- Loads a list of decimal operands and '+'/'*' operators in one cycle, then serialises them as ASCII characters, one per handshake: digit (op digit)*.
- Output is a valid/ready byte stream that downstream expression recognisers consume directly; every accepted string is well-formed by construction.

---
 rtl/expr_char_tx.sv | 99 +++++++++
 1 files changed

// File: rtl/expr_char_tx.sv
// expr_char_tx: serialises a loaded operand/operator list as an ASCII expression stream (digit (op digit)*).
// Define EXPR_CHAR_TX_EVAL_EN to also evaluate the expression ('*' before '+') into result.
module expr_char_tx #(
  parameter int MAX_TERMS = 8,
  parameter int CNT_W = 4,
  parameter int VAL_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [4*MAX_TERMS-1:0] operands,
  input  logic [MAX_TERMS-2:0]   ops,
  input  logic [CNT_W-1:0]       num_terms,
  output logic                   busy,
  output logic                   load_err,
  output logic [7:0]             out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   out_last,
  output logic                   done,
  output logic [VAL_W-1:0]       result,
  output logic                   result_valid
);
  localparam int N = 1 << CNT_W;
  typedef enum logic [1:0] {IDLE, DIGIT, OP, DONE} state_t;
  state_t state, state_n;
  logic [CNT_W-1:0] idx, num_r;
  // Latched lists are padded to the full index range so idx selects need no range guard.
  logic [4*N-1:0] opd_r;
  logic [N-1:0] ops_r;
  logic ok, xfer, last, load;
  logic [3:0] dig;
  always_comb begin
    ok = num_terms != '0 && int'(num_terms) <= MAX_TERMS;
    for (int i = 0; i < MAX_TERMS; i++)
      if (i < int'(num_terms) && operands[4*i +: 4] > 4'd9) ok = 1'b0;
  end
  always_comb begin
    dig = opd_r[{idx, 2'b00} +: 4];
    last = idx == num_r - CNT_W'(1);
    out_valid = state == DIGIT || state == OP;
    busy = out_valid;
    done = state == DONE;
    out_last = state == DIGIT && last;
    out_data = state == DIGIT ? 8'h30 + {4'h0, dig} : state == OP ? (ops_r[idx] ? 8'h2A : 8'h2B) : 8'h00;
    xfer = out_valid && out_ready;
    load = state == IDLE && start && ok;
    state_n = state == IDLE ? (load ? DIGIT : IDLE) :
              state == DIGIT ? (xfer ? (last ? DONE : OP) : DIGIT) :
              state == OP ? (xfer ? DIGIT : OP) : IDLE;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      load_err <= 1'b0;
      idx <= '0;
      num_r <= '0;
      opd_r <= '0;
      ops_r <= '0;
    end else begin
      state <= state_n;
      load_err <= state == IDLE && start && !ok;
      if (load) begin
        idx <= '0;
        num_r <= num_terms;
        opd_r <= (4*N)'(operands);
        ops_r <= N'(ops);
      end else if (state == OP && xfer) idx <= idx + CNT_W'(1);
    end
`ifdef EXPR_CHAR_TX_EVAL_EN
  logic [VAL_W-1:0] sum, prod, sum_n, prod_n, d, res;
  logic mul;
  // The operator preceding digit idx is ops[idx-1]; digit 0 is preloaded into prod.
  always_comb begin
    d = VAL_W'(dig);
    mul = ops_r[idx - CNT_W'(1)];
    sum_n = idx != '0 && !mul ? sum + prod : sum;
    prod_n = idx == '0 ? prod : mul ? prod * d : d;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      sum <= '0;
      prod <= '0;
      res <= '0;
    end else if (load) begin
      sum <= '0;
      prod <= VAL_W'(operands[3:0]);
    end else if (state == DIGIT && xfer) begin
      sum <= sum_n;
      prod <= prod_n;
      if (last) res <= sum_n + prod_n;
    end
  assign result = res;
  assign result_valid = done;
`else
  assign result = '0;
  assign result_valid = 1'b0;
`endif
endmodule
